// File: rtl/jk_bank_ctrl_pkg.sv
// jk_bank_ctrl_pkg: op/state types and per-bit JK helpers
// shared by the bank controller and its arbiter.
package jk_bank_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    SET    = 2'd1,
    RESET  = 2'd2,
    TOGGLE = 2'd3
  } jk_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } ctrl_state_e;

  // Per-bit {j,k} for an op; m is that bit's mask.
  function automatic logic [1:0] jk_encode(jk_op_e op, logic m);
    logic [1:0] r;
    r = 2'b00;
    unique case (op)
      HOLD:   r = 2'b00;
      SET:    r = {m, 1'b0};
      RESET:  r = {1'b0, m};
      TOGGLE: r = {m, m};
    endcase
    return r;
  endfunction

  // Per-bit JK flip-flop next state.
  function automatic logic jk_next(logic q_prev, logic j, logic k);
    logic r;
    r = q_prev;
    unique case ({j, k})
      2'b10:   r = 1'b1;
      2'b01:   r = 1'b0;
      2'b11:   r = ~q_prev;
      default: r = q_prev;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_bank_ctrl_arb.sv
// jk_rr_arb: two-way round-robin arbiter; the pointer
// moves to the requester that was not granted.
module jk_rr_arb
  import jk_bank_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (1'b1)
        (valid == 2'b11): gnt = ptr ? 2'b10 : 2'b01;
        (valid == 2'b01): gnt = 2'b01;
        (valid == 2'b10): gnt = 2'b10;
        default:          gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (|gnt) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: sequences a JK flip-flop bank for two requesters.
// Readback check/err_cnt present only with JK_BANK_CTRL_CHECK_EN.
module jk_bank_ctrl
  import jk_bank_ctrl_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [1:0]           req0_op,
  input  logic [WIDTH-1:0]     req0_mask,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [1:0]           req1_op,
  input  logic [WIDTH-1:0]     req1_mask,
  output logic [WIDTH-1:0]     j,
  output logic [WIDTH-1:0]     k,
  input  logic [WIDTH-1:0]     q,
  output logic                 done,
  output logic                 done_id,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  ctrl_state_e      state;
  ctrl_state_e      state_d;
  logic [1:0]       gnt;
  logic             arb_en;
  jk_op_e           op_sel;
  logic [WIDTH-1:0] mask_sel;
  logic [WIDTH-1:0] enc_j;
  logic [WIDTH-1:0] enc_k;
  jk_op_e           op_q;
  logic [WIDTH-1:0] mask_q;
  logic             id_q;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic             load;
  logic             done_d;
  logic             err_d;
  logic             mismatch;

  // Grants only in IDLE and never while reset is held.
  assign arb_en = (state == IDLE) && !rst;

  jk_rr_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid ({req1_valid, req0_valid}),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign op_sel   = gnt[1] ? jk_op_e'(req1_op) : jk_op_e'(req0_op);
  assign mask_sel = gnt[1] ? req1_mask : req0_mask;

  always_comb begin
    enc_j = '0;
    enc_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {enc_j[i], enc_k[i]} = jk_encode(op_sel, mask_sel[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|gnt) begin
          load    = 1'b1;
          j_d     = enc_j;
          k_d     = enc_k;
          state_d = DRIVE;
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        done_d  = 1'b1;
        err_d   = mismatch;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j       <= '0;
      k       <= '0;
      done    <= 1'b0;
      done_id <= 1'b0;
      err     <= 1'b0;
      op_q    <= HOLD;
      mask_q  <= '0;
      id_q    <= 1'b0;
    end else begin
      j    <= j_d;
      k    <= k_d;
      done <= done_d;
      err  <= err_d;
      if (done_d) begin
        done_id <= id_q;
      end
      if (load) begin
        op_q   <= op_sel;
        mask_q <= mask_sel;
        id_q   <= gnt[1];
      end
    end
  end

`ifdef JK_BANK_CTRL_CHECK_EN
  logic [WIDTH-1:0]     shadow;
  logic [WIDTH-1:0]     shadow_nxt;
  logic [WIDTH-1:0]     chk_j;
  logic [WIDTH-1:0]     chk_k;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Re-derive the driven j/k from the latched command.
  always_comb begin
    chk_j      = '0;
    chk_k      = '0;
    shadow_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {chk_j[i], chk_k[i]} = jk_encode(op_q, mask_q[i]);
      shadow_nxt[i] = jk_next(shadow[i], chk_j[i], chk_k[i]);
    end
  end

  assign mismatch = (state == CHECK) && (q != shadow_nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      err_cnt_q <= '0;
    end else if (state == CHECK) begin
      shadow <= shadow_nxt;
      if (mismatch && !(&err_cnt_q)) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_chk;

  assign mismatch   = 1'b0;
  assign err_cnt    = '0;
  assign unused_chk = ^{q, op_q, mask_q};
`endif

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// tb_jk_bank_ctrl: randomized scoreboard bench with a behavioural
// JK bank; expectations follow JK_BANK_CTRL_CHECK_EN when defined.
module tb_jk_bank_ctrl;

  localparam int W    = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    v   = 2'b00;
  logic [1:0]    op [2];
  logic [W-1:0]  mk [2];
  logic          rdy0, rdy1;
  logic [W-1:0]  j, k, q;
  logic          done, done_id, err;
  logic [CW-1:0] err_cnt;
  logic [W-1:0]  bank;
  logic [W-1:0]  corrupt = '0;
  logic [1:0]    acc = 2'b00;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign q = bank ^ corrupt;

  jk_bank_ctrl #(.WIDTH(W), .ERR_CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (v[0]),
    .req0_ready (rdy0),
    .req0_op    (op[0]),
    .req0_mask  (mk[0]),
    .req1_valid (v[1]),
    .req1_ready (rdy1),
    .req1_op    (op[1]),
    .req1_mask  (mk[1]),
    .j          (j),
    .k          (k),
    .q          (q),
    .done       (done),
    .done_id    (done_id),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  // The external JK bank.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bank <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        case ({j[i], k[i]})
          2'b10:   bank[i] <= 1'b1;
          2'b01:   bank[i] <= 1'b0;
          2'b11:   bank[i] <= ~bank[i];
          default: bank[i] <= bank[i];
        endcase
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    int           id;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         err;
    int           cnt;
    int           acc;
  } exp_t;

  exp_t         sbq[$];
  exp_t         ent;
  int           cyc      = 0;
  int           last_acc = -100;
  int           ptr_m    = 0;
  int           cnt_m    = 0;
  int           win;
  logic [W-1:0] dj = '0, dk = '0;
  logic [W-1:0] ej, ek, mm;
  logic         exp_any;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      sbq.delete();
      last_acc = -100;
      ptr_m    = 0;
      cnt_m    = 0;
      check("rst_jk", {j, k}, 0);
      check("rst_out", {done, err, rdy1, rdy0}, 0);
      check("rst_cnt", err_cnt, 0);
      continue;
    end
    ej = (cyc == last_acc + 1) ? dj : '0;
    ek = (cyc == last_acc + 1) ? dk : '0;
    check("drive_j", j, ej);
    check("drive_k", k, ek);
    exp_any = (cyc >= last_acc + 3) && (v != 2'b00);
    check("ready_any", (rdy0 | rdy1), exp_any);
    if (rdy0 | rdy1) begin
      win = (v == 2'b11) ? ptr_m : (v[0] ? 0 : 1);
      check("grant", {rdy1, rdy0}, 32'(1) << win);
      ptr_m = 1 - win;
      mm = mk[win];
      dj = '0;
      dk = '0;
      case (op[win])
        2'd1:    dj = mm;
        2'd2:    dk = mm;
        2'd3:    begin dj = mm; dk = mm; end
        default: ;
      endcase
      ent.id  = win;
      ent.j   = dj;
      ent.k   = dk;
`ifdef JK_BANK_CTRL_CHECK_EN
      ent.err = (corrupt != '0);
`else
      ent.err = 1'b0;
`endif
      if (ent.err && cnt_m < CMAX) cnt_m++;
      ent.cnt = cnt_m;
      ent.acc = cyc;
      sbq.push_back(ent);
      last_acc = cyc;
    end
    if (done) begin
      if (sbq.size() == 0) begin
        check("done_unexpected", done, 0);
      end else begin
        ent = sbq.pop_front();
        check("done_latency", cyc, ent.acc + 3);
        check("done_id", done_id, ent.id);
        check("err", err, ent.err);
        check("err_cnt", err_cnt, ent.cnt);
      end
    end else begin
      check("err_without_done", err, 0);
      if (sbq.size() > 0 && cyc > sbq[0].acc + 3) begin
        check("done_missing", done, 1);
        void'(sbq.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc_step();
    @(negedge clk);
    acc = v & {rdy1, rdy0};
    @(posedge clk);
    #1;
  endtask

  task automatic issue(int r, int o, int m);
    v[r]  = 1'b1;
    op[r] = 2'(o);
    mk[r] = W'(m);
    for (int n = 0; n < 20; n++) begin
      cyc_step();
      if (acc[r]) break;
    end
    check("issue_accept", acc[r], 1);
    v[r] = 1'b0;
  endtask

  task automatic idle(int n);
    v = 2'b00;
    repeat (n) cyc_step();
  endtask

  task automatic traffic(int n, int pct);
    repeat (n) begin
      for (int r = 0; r < 2; r++) begin
        if (!v[r] || acc[r]) begin
          v[r]  = ($urandom_range(99) < pct);
          op[r] = 2'($urandom_range(3));
          mk[r] = W'($urandom_range(15));
        end
      end
      cyc_step();
    end
  endtask

  logic [W-1:0] qsave;

  initial begin
    op[0] = 2'd0; op[1] = 2'd0;
    mk[0] = '0;   mk[1] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    issue(0, 1, 4'b0101);
    idle(4);
    check("q_set", q, 4'b0101);

    issue(1, 3, 4'b1111);
    idle(4);
    check("q_toggle", q, 4'b1010);

    corrupt = 4'b0010;
    issue(0, 0, 4'b0000);
    idle(4);
    corrupt = '0;

    traffic(30, 100);
    idle(4);

    qsave = q;
    issue(0, 0, 4'b1111);
    issue(1, 1, 4'b0000);
    idle(4);
    check("q_hold", q, qsave);

    traffic(200, 60);
    idle(4);

    issue(0, 3, 4'b1111);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_jk", {j, k}, 0);
    check("rst_async_rdy", {rdy1, rdy0}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_cnt_clear", err_cnt, 0);
    issue(1, 1, 4'b0011);
    idle(4);
    check("q_after_rst", q, 4'b0011);

    corrupt = 4'b0001;
    for (int i = 0; i < 300; i++) begin
      issue(i % 2, $urandom_range(3), $urandom_range(15));
    end
    idle(4);
    corrupt = '0;
`ifdef JK_BANK_CTRL_CHECK_EN
    check("err_cnt_sat", err_cnt, CMAX);
`else
    check("err_cnt_sat", err_cnt, 0);
`endif
    check("sb_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
- Sequences a bank of WIDTH external JK flip-flops on behalf of two requesters.
- Arbitrates round-robin between the requesters and accepts one command per grant over a valid/ready handshake.
- Drives the bank's j/k inputs for exactly one clock, then reads q back and checks it against a shadow model.
- Sits between software-facing command sources and the JK register bank; shares the bank's clk and rst.

Parameters:
- WIDTH, 4, number of JK flip-flops in the controlled bank.
- ERR_CNT_W, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  bank clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset, shared with the JK bank.
- req0_valid  input  1  requester 0 has a command.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_op  input  2  requester 0 op: 0 HOLD, 1 SET, 2 RESET, 3 TOGGLE.
- req0_mask  input  WIDTH  requester 0 bits affected by the op.
- req1_valid, req1_ready, req1_op, req1_mask: same as requester 0.
- j  output  WIDTH  J inputs to the bank.
- k  output  WIDTH  K inputs to the bank.
- q  input  WIDTH  Q outputs of the bank.
- done  output  1  one-cycle pulse when a command completes.
- done_id  output  1  requester index of the completed command.
- err  output  1  qualified by done; high when readback mismatched.
- err_cnt  output  ERR_CNT_W  saturating count of mismatches.

Behaviour:
- Reset, asynchronous: state=IDLE, j=k=0, done=0, done_id=0, err=0, err_cnt=0, shadow=0, RR pointer=requester 0, both readies=0.
- Reset asserted mid-operation aborts the command: no done pulse, j/k drop to 0 immediately.
- FSM states: IDLE, DRIVE, CHECK.
- IDLE:
  - If any valid is high, grant one requester and assert its ready combinationally that cycle.
  - If both are valid, the requester at the RR pointer wins; the pointer then moves to the other requester.
  - A single valid requester always wins; the pointer then moves to the requester that was not granted.
  - Latch op, mask and id; go to DRIVE.
  - Neither ready is asserted outside IDLE.
- DRIVE (one cycle): j/k are registered outputs, set on entry.
  - Masked bits: HOLD j=0,k=0; SET j=1,k=0; RESET j=0,k=1; TOGGLE j=1,k=1.
  - Unmasked bits: j=k=0.
  - The bank updates on the rising edge that ends DRIVE. Go to CHECK.
- CHECK (one cycle): j=k=0.
  - Compute expected from shadow with JK semantics per bit.
  - Shadow <= expected.
  - If q != expected: err=1 and err_cnt += 1, saturating at all-ones.
  - Go to IDLE.
- done/done_id/err are registered: they pulse for the one cycle after CHECK, which is the first IDLE cycle.
- A new grant may occur in that same cycle.
- Latency: handshake at cycle T; j/k valid at T+1; q checked at T+2; done at T+3.
- Throughput: one command per 3 cycles.
- mask=0 behaves as HOLD and still completes with done.
- err stays 0 whenever done is 0.

Optional Feature:
- Macro JK_BANK_CTRL_CHECK_EN.
- Defined: shadow register, compare logic and err_cnt are present, as described above.
- Undefined: shadow and compare logic are removed; err and err_cnt are tied to 0.
- Undefined keeps CHECK and keeps latency and throughput identical, so benches are timing-compatible.

Decomposition:
- Package jk_bank_ctrl_pkg holds:
  - typedef enum logic [1:0] jk_op_e {HOLD, SET, RESET, TOGGLE};
  - typedef enum ctrl_state_e {IDLE, DRIVE, CHECK};
  - function jk_encode(op, mask) returning {j,k};
  - function jk_next(q_prev, j, k) for the shadow model and the scoreboard.
- One natural sub-module: jk_rr_arb, the 2-way round-robin arbiter (valid in, one-hot grant out, pointer update on accept).

Test Plan:
- Reset, then req0 SET mask 4'b0101 -> req0_ready at T; j=0101, k=0000 at T+1; q=0101; done=1, done_id=0, err=0 at T+3.
- From q=0101, req1 TOGGLE mask 4'b1111 -> j=k=1111 for one cycle; q=1010; done_id=1, err=0.
- After reset, req0 and req1 valid continuously -> grants alternate 0,1,0,1; done_id sequence 0,1,0,1, one command every 3 cycles.
- Bench forces q=1000 when 1010 is expected -> err=1 with done and err_cnt=1; 300 forced mismatches -> err_cnt saturates at 255.
- rst asserted during DRIVE -> j=k=0 in the same cycle, state IDLE, no done pulse, err_cnt=0; after release, the next command completes normally.
- HOLD with mask 4'b1111, and SET with mask 0 -> j=k=0 throughout, q unchanged, done pulses, err=0.
